// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Shares the register file's single write port between two writeback sources:
//   A - ALU / pipeline writeback
//   B - long-latency unit writeback (loads, mul/div)
//
// Each source hands its write into a one-entry holding buffer over a
// valid/ready handshake. Every cycle at most one buffered entry is granted the
// regfile write port:
//   - a lone occupied buffer always wins;
//   - two writes to the same register leave in arrival order (B first when
//     both arrived together);
//   - otherwise A wins, unless B has already waited STARVE_MAX cycles.
// The grant depends only on registered buffer state, so nothing on the input
// side reaches the regfile outputs combinationally.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       synchronous active-low reset; drops any buffered writes
//   a_valid_i    source A write request
//   a_ready_o    source A may hand over this cycle
//   a_addr_i     source A destination register
//   a_data_i     source A write data
//   b_valid_i    source B write request
//   b_ready_o    source B may hand over this cycle
//   b_addr_i     source B destination register
//   b_data_i     source B write data
//   rf_wen_o     regfile write enable
//   rf_waddr_o   regfile write address (0 when idle)
//   rf_wdata_o   regfile write data (0 when idle)
//   pend_mask_o  bit i set while a buffered write to register i is outstanding
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              rf_wen_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [31:0]       pend_mask_o
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  // Holding buffers. The age bit is 1 for the entry that arrived first; it
  // only carries meaning while both buffers are occupied.
  logic              a_vld_reg, a_vld_next;
  logic [ADDR_W-1:0] a_addr_reg, a_addr_next;
  logic [DATA_W-1:0] a_data_reg, a_data_next;
  logic              a_age_reg, a_age_next;

  logic              b_vld_reg, b_vld_next;
  logic [ADDR_W-1:0] b_addr_reg, b_addr_next;
  logic [DATA_W-1:0] b_data_reg, b_data_next;
  logic              b_age_reg, b_age_next;

  logic [STARVE_W-1:0] starve_reg, starve_next;
  logic [31:0]         pend_reg, pend_next;

  logic grant_a, grant_b;
  logic a_load, b_load;
  logic a_hold, b_hold;

  // ---------------------------------------------------------------------------
  // Grant: purely from buffer state.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_vld_reg && b_vld_reg) begin
      if (a_addr_reg == b_addr_reg) begin
        // Same destination: keep program order. Ages are complementary here.
        grant_b = b_age_reg;
      end else begin
        grant_b = (starve_reg == STARVE_LIM);
      end
      grant_a = !grant_b;
    end else begin
      grant_a = a_vld_reg;
      grant_b = b_vld_reg;
    end
  end

  // A buffer can take a new entry when empty or when it drains this cycle.
  assign a_ready_o = !a_vld_reg || grant_a;
  assign b_ready_o = !b_vld_reg || grant_b;

  // Writes to x0 complete the handshake but never occupy a buffer.
  assign a_load = a_valid_i && a_ready_o && (a_addr_i != '0);
  assign b_load = b_valid_i && b_ready_o && (b_addr_i != '0);

  // An entry that stays put across the next edge.
  assign a_hold = a_vld_reg && !grant_a;
  assign b_hold = b_vld_reg && !grant_b;

  assign rf_wen_o   = grant_a || grant_b;
  assign rf_waddr_o = grant_b ? b_addr_reg : (grant_a ? a_addr_reg : '0);
  assign rf_wdata_o = grant_b ? b_data_reg : (grant_a ? a_data_reg : '0);

  // ---------------------------------------------------------------------------
  // Buffer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_vld_next  = a_load || a_hold;
    a_addr_next = a_load ? a_addr_i : a_addr_reg;
    a_data_next = a_load ? a_data_i : a_data_reg;

    b_vld_next  = b_load || b_hold;
    b_addr_next = b_load ? b_addr_i : b_addr_reg;
    b_data_next = b_load ? b_data_i : b_data_reg;

    // A fresh entry is older only if nothing else will be sitting beside it.
    // When both arrive together B is the older one. An entry that stays while
    // the other side loads becomes the older one.
    if (a_load) begin
      a_age_next = !(b_hold || b_load);
    end else if (b_load) begin
      a_age_next = a_hold;
    end else begin
      a_age_next = a_age_reg && a_vld_next;
    end

    if (b_load) begin
      b_age_next = !a_hold;
    end else if (a_load) begin
      b_age_next = b_hold;
    end else begin
      b_age_next = b_age_reg && b_vld_next;
    end
  end

  // B's waiting time, only counted while it is occupied and losing.
  always_comb begin
    starve_next = '0;
    if (b_hold) begin
      starve_next = (starve_reg == STARVE_LIM) ? starve_reg : starve_reg + 1'b1;
    end
  end

  // Pending mask describes the buffers as they will be after this edge, so a
  // drained entry disappears one cycle after its grant unless refilled.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      assign pend_next[gi] = (a_vld_next && (a_addr_next == ADDR_W'(gi))) ||
                             (b_vld_next && (b_addr_next == ADDR_W'(gi)));
    end
  endgenerate

  assign pend_mask_o = pend_reg;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_vld_reg  <= 1'b0;
      a_addr_reg <= '0;
      a_data_reg <= '0;
      a_age_reg  <= 1'b0;
      b_vld_reg  <= 1'b0;
      b_addr_reg <= '0;
      b_data_reg <= '0;
      b_age_reg  <= 1'b0;
      starve_reg <= '0;
      pend_reg   <= '0;
    end else begin
      a_vld_reg  <= a_vld_next;
      a_addr_reg <= a_addr_next;
      a_data_reg <= a_data_next;
      a_age_reg  <= a_age_next;
      b_vld_reg  <= b_vld_next;
      b_addr_reg <= b_addr_next;
      b_data_reg <= b_data_next;
      b_age_reg  <= b_age_next;
      starve_reg <= starve_next;
      pend_reg   <= pend_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic. A behavioural model tracks each buffered write with its arrival
// cycle and B's waiting time, and predicts every output on every cycle. The
// regfile contents seen by the DUT are also compared at the end against the
// last value accepted per register.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SM = 3;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic          a_valid_i = 1'b0;
  logic          a_ready_o;
  logic [AW-1:0] a_addr_i = '0;
  logic [DW-1:0] a_data_i = '0;
  logic          b_valid_i = 1'b0;
  logic          b_ready_o;
  logic [AW-1:0] b_addr_i = '0;
  logic [DW-1:0] b_data_i = '0;
  logic          rf_wen_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [31:0]   pend_mask_o;

  rf_wb_arbiter #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .STARVE_MAX(SM)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .a_valid_i  (a_valid_i),
    .a_ready_o  (a_ready_o),
    .a_addr_i   (a_addr_i),
    .a_data_i   (a_data_i),
    .b_valid_i  (b_valid_i),
    .b_ready_o  (b_ready_o),
    .b_addr_i   (b_addr_i),
    .b_data_i   (b_data_i),
    .rf_wen_o   (rf_wen_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .pend_mask_o(pend_mask_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model: index 0 = source A, 1 = source B.
  bit            m_init = 1'b0;
  bit            m_v    [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int            m_stamp[2];
  int            m_wait;
  int            cyc = 0;
  logic [DW-1:0] ref_rf [32];
  logic [DW-1:0] dut_rf [32];

  int            g;
  logic          e_wen, e_ar, e_br;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [31:0]   e_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] check %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Compare process: predict this cycle's outputs, compare, then advance the
  // model to the state after the coming rising edge.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      g = -1;
      if (m_v[0] && m_v[1]) begin
        if (m_addr[0] == m_addr[1]) g = (m_stamp[1] <= m_stamp[0]) ? 1 : 0;
        else                        g = (m_wait >= SM) ? 1 : 0;
      end else if (m_v[0]) begin
        g = 0;
      end else if (m_v[1]) begin
        g = 1;
      end
      e_wen  = (g >= 0);
      e_addr = (g >= 0) ? m_addr[g] : '0;
      e_data = (g >= 0) ? m_data[g] : '0;
      e_ar   = !m_v[0] || (g == 0);
      e_br   = !m_v[1] || (g == 1);
      e_pend = '0;
      for (int s = 0; s < 2; s++) if (m_v[s]) e_pend[m_addr[s]] = 1'b1;

      if (m_init) begin
        tests_run++;
        if (rf_wen_o !== e_wen || rf_waddr_o !== e_addr || rf_wdata_o !== e_data ||
            pend_mask_o !== e_pend || a_ready_o !== e_ar || b_ready_o !== e_br) begin
          tests_failed++;
          $display("FAIL cycle_cmp t=%0t: got wen=%0b addr=%0d data=%h pend=%h ar=%0b br=%0b, expected wen=%0b addr=%0d data=%h pend=%h ar=%0b br=%0b",
                   $time, rf_wen_o, rf_waddr_o, rf_wdata_o, pend_mask_o, a_ready_o, b_ready_o,
                   e_wen, e_addr, e_data, e_pend, e_ar, e_br);
        end
        if (rst_ni && rf_wen_o === 1'b1) begin
          dut_rf[rf_waddr_o] = rf_wdata_o;
          $display("[TB] t=%0t write x%0d = 0x%08h", $time, rf_waddr_o, rf_wdata_o);
        end
      end

      if (!rst_ni) begin
        m_init = 1'b1;
        m_v[0] = 1'b0;
        m_v[1] = 1'b0;
        m_wait = 0;
        for (int r = 0; r < 32; r++) begin
          ref_rf[r] = '0;
          dut_rf[r] = '0;
        end
      end else if (m_init) begin
        if (m_v[1] && g != 1) m_wait = (m_wait < SM) ? m_wait + 1 : SM;
        else                  m_wait = 0;
        if (g >= 0) m_v[g] = 1'b0;
        // B before A so that a same-cycle pair leaves A's value as the last.
        if (b_valid_i && e_br && b_addr_i != '0) begin
          m_v[1] = 1'b1; m_addr[1] = b_addr_i; m_data[1] = b_data_i; m_stamp[1] = cyc;
          ref_rf[b_addr_i] = b_data_i;
        end
        if (a_valid_i && e_ar && a_addr_i != '0) begin
          m_v[0] = 1'b1; m_addr[0] = a_addr_i; m_data[0] = a_data_i; m_stamp[0] = cyc;
          ref_rf[a_addr_i] = a_data_i;
        end
      end
    end
  end

  task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_valid_i = v; a_addr_i = ad; a_data_i = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_valid_i = v; b_addr_i = ad; b_data_i = d;
  endtask

  initial begin
    // Reset
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    chk("reset_wen", rf_wen_o, 0);
    chk("reset_pend", pend_mask_o, 0);
    chk("reset_a_ready", a_ready_o, 1);
    chk("reset_b_ready", b_ready_o, 1);

    // Single A write x5 = 0x1234
    drive_a(1, 5, 32'h1234);
    tick();
    drive_a(0, 0, 0);
    chk("a_x5_wen", rf_wen_o, 1);
    chk("a_x5_addr", rf_waddr_o, 5);
    chk("a_x5_data", rf_wdata_o, 32'h1234);
    chk("a_x5_pend", pend_mask_o, 32'h20);
    tick();
    chk("a_x5_done_wen", rf_wen_o, 0);
    chk("a_x5_done_pend", pend_mask_o, 0);

    // A x3 and B x4 together: A first, B back-pressured
    drive_a(1, 3, 32'hA);
    drive_b(1, 4, 32'hB);
    tick();
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    chk("pair_first_addr", rf_waddr_o, 3);
    chk("pair_first_data", rf_wdata_o, 32'hA);
    chk("pair_b_ready", b_ready_o, 0);
    tick();
    chk("pair_second_addr", rf_waddr_o, 4);
    chk("pair_second_data", rf_wdata_o, 32'hB);
    tick();

    // Starvation: A streams while B holds x7
    drive_a(1, 10, 32'h10);
    drive_b(1, 7, 32'hBEEF);
    tick();
    drive_b(0, 0, 0);
    drive_a(1, 11, 32'h11);
    chk("starve_c1_addr", rf_waddr_o, 10);
    tick();
    drive_a(1, 12, 32'h12);
    chk("starve_c2_addr", rf_waddr_o, 11);
    tick();
    drive_a(1, 13, 32'h13);
    chk("starve_c3_addr", rf_waddr_o, 12);
    tick();
    drive_a(1, 14, 32'h14);
    chk("starve_b_addr", rf_waddr_o, 7);
    chk("starve_b_data", rf_wdata_o, 32'hBEEF);
    chk("starve_a_ready", a_ready_o, 0);
    tick();
    chk("starve_c5_addr", rf_waddr_o, 13);
    chk("starve_c5_a_ready", a_ready_o, 1);
    tick();
    drive_a(0, 0, 0);
    chk("starve_c6_addr", rf_waddr_o, 14);
    tick();

    // Same address, B then A on consecutive cycles
    drive_b(1, 9, 32'h1);
    tick();
    drive_b(0, 0, 0);
    drive_a(1, 9, 32'h2);
    chk("order_seq_first", rf_wdata_o, 32'h1);
    tick();
    drive_a(0, 0, 0);
    chk("order_seq_second", rf_wdata_o, 32'h2);
    tick();
    // Same address, same cycle: B first
    drive_a(1, 9, 32'h22);
    drive_b(1, 9, 32'h11);
    tick();
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    chk("order_same_first", rf_wdata_o, 32'h11);
    tick();
    chk("order_same_second", rf_wdata_o, 32'h22);
    tick();

    // Write to x0 is accepted and dropped
    drive_a(1, 0, 32'hFFFF);
    chk("x0_a_ready", a_ready_o, 1);
    tick();
    drive_a(0, 0, 0);
    chk("x0_wen", rf_wen_o, 0);
    chk("x0_pend", pend_mask_o, 0);
    tick();

    // Reset with both buffers full
    drive_a(1, 3, 32'h33);
    drive_b(1, 4, 32'h44);
    tick();
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    chk("full_pend", pend_mask_o, 32'h18);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rst_full_wen", rf_wen_o, 0);
    chk("rst_full_pend", pend_mask_o, 0);
    chk("rst_full_a_ready", a_ready_o, 1);
    chk("rst_full_b_ready", b_ready_o, 1);
    tick();
    chk("rst_full_wen_later", rf_wen_o, 0);

    // Randomized traffic in phases of differing load and address spread
    for (int ph = 0; ph < 6; ph++) begin
      int pa, pb;
      pa = 30 + 14 * ph;
      if (pa > 100) pa = 100;
      pb = 20 + 15 * ph;
      if (pb > 90) pb = 90;
      for (int i = 0; i < 500; i++) begin
        tick();
        rst_ni    = ($urandom_range(0, 299) != 0);
        a_valid_i = ($urandom_range(0, 99) < pa);
        b_valid_i = ($urandom_range(0, 99) < pb);
        a_addr_i  = (ph % 2 == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
        b_addr_i  = (ph % 2 == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
        a_data_i  = $urandom;
        b_data_i  = $urandom;
      end
    end

    // Drain and compare final register contents
    tick();
    rst_ni = 1'b1;
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    for (int r = 1; r < 32; r++) chk($sformatf("final_x%0d", r), dut_rf[r], ref_rf[r]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name:
rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
- Source A is the ALU/pipeline writeback. Source B is the long-latency unit (load/mul-div writeback).
- Each source has a one-entry holding buffer with valid/ready handshake. Selection is fixed-priority with anti-starvation, and same-address writes are ordered oldest-first.
- Drives the regfile write port directly and exports a pending-write mask for the hazard/stall logic.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- STARVE_MAX, 3, consecutive cycles B may wait while occupied before it is forced to win

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  reset, synchronous, active-low
- a_valid_i  input  1  source A write request
- a_ready_o  output  1  source A may hand over this cycle
- a_addr_i  input  ADDR_W  source A destination register
- a_data_i  input  DATA_W  source A write data
- b_valid_i  input  1  source B write request
- b_ready_o  output  1  source B may hand over this cycle
- b_addr_i  input  ADDR_W  source B destination register
- b_data_i  input  DATA_W  source B write data
- rf_wen_o  output  1  regfile write enable
- rf_waddr_o  output  ADDR_W  regfile write address
- rf_wdata_o  output  DATA_W  regfile write data
- pend_mask_o  output  32  bit i = 1 while a buffered write to register i is outstanding

Behaviour:
- State per source: buffer valid bit, addr, data, age bit (1 = older). Shared: starvation counter starve_q, width clog2(STARVE_MAX+1).
- Reset (rst_ni = 0 at a clock edge):
  - buffer valids, age bits and starve_q clear to 0;
  - in-flight writes are discarded, not committed;
  - rf_wen_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, pend_mask_o = 0 from the first cycle after reset;
  - a_ready_o = b_ready_o = 1.
- Handshake:
  - transfer occurs when valid_i && ready_o at the clock edge;
  - ready_o = !buf_valid || grant to that source this cycle (a buffer may be refilled in the same cycle it drains);
  - a transfer with addr == 0 is accepted and dropped: the buffer is not loaded and rf_wen_o is never raised for it.
- Grant (combinational from buffer state only; no input-to-output combinational path):
  - only one buffer occupied: grant it;
  - both occupied, same address: grant the older (age bit); if they were loaded in the same cycle, B counts as older;
  - both occupied, different addresses: grant B if starve_q == STARVE_MAX, else grant A;
  - rf_wen_o = 1 iff any grant; rf_waddr_o/rf_wdata_o carry the granted entry, else 0.
- Latency: data accepted at edge t drives rf_wen_o during cycle t+1 at the earliest, and is written to the regfile at edge t+1+wait.
- Throughput: one regfile write per cycle. A sustains one write per cycle when B is idle.
- Starvation counter:
  - starve_q increments when B is occupied and not granted, saturating at STARVE_MAX;
  - it clears to 0 when B is granted or B is empty.
- Age:
  - when a buffer loads while the other remains occupied (not granted this cycle), the newly loaded entry is younger;
  - when a buffer loads and the other is empty or draining, the new entry is older;
  - when both load in the same cycle, B is older.
- pend_mask_o:
  - registered from buffer contents: OR of one-hot(addr) over valid buffers;
  - a bit clears in the cycle after its grant unless that register is reloaded in the same edge.
- Simultaneous events:
  - a grant and a refill of the same buffer on one edge is legal: the old entry is written, the new entry occupies the buffer;
  - both sources request while both buffers are full: only the granted source's ready_o = 1.

Test Plan:
- Reset then A writes x5 = 0x1234 (one cycle) → next cycle rf_wen_o = 1, waddr 5, wdata 0x1234; pend_mask_o bit5 = 1 for one cycle.
- A and B request the same cycle (A: x3 = 0xA, B: x4 = 0xB), A then idle → cycle+1 writes x3, cycle+2 writes x4; b_ready_o = 0 during cycle+1.
- A streams a valid write every cycle while B holds x7 = 0xBEEF, STARVE_MAX = 3 → B written exactly 4 cycles after its acceptance; A is back-pressured that cycle only; starve_q returns to 0.
- Same-address ordering: B loads x9 = 1, A loads x9 = 2 in the next cycle → regfile sees x9 = 1 then x9 = 2. Both loaded in the same cycle → B's value is written first.
- Write to x0 from A (data 0xFFFF) → a_ready_o = 1, rf_wen_o stays 0, pend_mask_o = 0.
- rst_ni low for 1 cycle while both buffers are full → no rf_wen_o afterwards, pend_mask_o = 0, both ready_o = 1, starve_q = 0.
